// File: rtl/data_demultiplexer_if.sv
// Stream interfaces for the demultiplexer: a plain ready/valid token channel
// and a multi-tuple packet channel with keep/last framing.
interface ready_valid_i #(
   parameter int unsigned DATA_W = 2
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport m (output data, output valid, input  ready);
   modport s (input  data, input  valid, output ready);
endinterface

interface ndata_i #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned NUM_TUPLES = 1
);
   logic [NUM_TUPLES-1:0][DATA_W-1:0] data;
   logic [NUM_TUPLES-1:0]             keep;
   logic                              last;
   logic                              valid;
   logic                              ready;

   modport m (output data, output keep, output last, output valid, input  ready);
   modport s (input  data, input  keep, input  last, input  valid, output ready);
endinterface

// File: rtl/data_demultiplexer.sv
// Packet-granular demultiplexer: one select token steers a whole packet to one
// of NUM_STREAMS outputs; out-of-range selects discard the packet.
module data_demultiplexer #(
   parameter int unsigned NUM_STREAMS = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   ready_valid_i.s  select,
   ndata_i.s        in,
   ndata_i.m        out [NUM_STREAMS]
);
   localparam int unsigned SEL_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUTE = 2'd1,
      S_DROP  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [SEL_W-1:0]     dest_q, dest_d;
   logic                 live_q, live_d;
   logic [NUM_STREAMS-1:0] out_ready;
   logic                 dest_ready_c;
   logic                 in_ready_c;
   logic                 sel_ready_c;
   logic                 sel_in_range_c;
   logic                 eop_c;
   logic                 route_c;

   // Data, keep and last fan out to every lane; only valid is steered.
   for (genvar i = 0; i < int'(NUM_STREAMS); i++) begin : g_lane
      assign out[i].data  = in.data;
      assign out[i].keep  = in.keep;
      assign out[i].last  = in.last;
      assign out[i].valid = route_c & in.valid & (32'(dest_q) == 32'(i));
      assign out_ready[i] = out[i].ready;
   end

   assign route_c      = (state_q == S_ROUTE);
   assign in.ready     = in_ready_c;
   assign select.ready = sel_ready_c;

   // Ready of the latched lane, selected by comparison so dest never indexes past the array.
   always_comb begin
      dest_ready_c = 1'b0;
      for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
         if (32'(dest_q) == i) dest_ready_c = out_ready[i];
      end
   end

   always_comb begin
      state_d        = state_q;
      dest_d         = dest_q;
      live_d         = 1'b1;
      in_ready_c     = 1'b0;
      sel_ready_c    = 1'b0;
      sel_in_range_c = (32'(select.data) < NUM_STREAMS);

      unique case (state_q)
         S_IDLE:  sel_ready_c = live_q;
         S_ROUTE: in_ready_c  = dest_ready_c;
         S_DROP:  in_ready_c  = 1'b1;
         default: state_d     = S_IDLE;
      endcase

      // The last beat reopens the select channel in the same cycle.
      eop_c = in.valid & in_ready_c & in.last;
      if (eop_c) begin
         sel_ready_c = live_q;
         state_d     = S_IDLE;
      end

      if (sel_ready_c && select.valid) begin
         dest_d  = SEL_W'(select.data);
         state_d = sel_in_range_c ? S_ROUTE : S_DROP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         dest_q  <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         live_q  <= live_d;
      end
   end
endmodule

// File: tb/tb_data_demultiplexer.sv
// Directed bench for data_demultiplexer: a 4-lane instance for routing,
// backpressure and reset cases, and a 3-lane instance for out-of-range drops.
module tb_data_demultiplexer;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   ready_valid_i #(.DATA_W(2))                  sel4 ();
   ndata_i       #(.DATA_W(8), .NUM_TUPLES(1))  in4 ();
   ndata_i       #(.DATA_W(8), .NUM_TUPLES(1))  out4 [4] ();
   ready_valid_i #(.DATA_W(2))                  sel3 ();
   ndata_i       #(.DATA_W(8), .NUM_TUPLES(1))  in3 ();
   ndata_i       #(.DATA_W(8), .NUM_TUPLES(1))  out3 [3] ();

   logic [3:0] v4, rdy4;
   logic [2:0] v3, rdy3;
   logic [7:0] d4, d3;

   data_demultiplexer #(.NUM_STREAMS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .select(sel4), .in(in4), .out(out4));
   data_demultiplexer #(.NUM_STREAMS(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .select(sel3), .in(in3), .out(out3));

   for (genvar i = 0; i < 4; i++) begin : g4
      assign v4[i]        = out4[i].valid;
      assign out4[i].ready = rdy4[i];
   end
   for (genvar i = 0; i < 3; i++) begin : g3
      assign v3[i]        = out3[i].valid;
      assign out3[i].ready = rdy3[i];
   end
   assign d4 = out4[0].data[0];
   assign d3 = out3[0].data[0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One cycle on the 4-lane DUT: drive at edge+1, check mid-cycle, advance.
   task automatic cyc4(input string tag, input bit sv, input logic [1:0] sd,
                       input bit iv, input logic [7:0] d, input bit l, input logic [3:0] rdy,
                       input bit e_sr, input bit e_ir, input logic [3:0] e_v);
      sel4.valid = sv; sel4.data = sd;
      in4.valid = iv; in4.data[0] = d; in4.last = l; rdy4 = rdy;
      #4;
      check_eq({tag, ".sel_rdy"}, 32'(sel4.ready), 32'(e_sr));
      check_eq({tag, ".in_rdy"},  32'(in4.ready),  32'(e_ir));
      check_eq({tag, ".valid"},   32'(v4),         32'(e_v));
      if (e_v != 4'd0) check_eq({tag, ".data"}, 32'(d4), 32'(d));
      @(posedge clk); #1;
   endtask

   task automatic cyc3(input string tag, input bit sv, input logic [1:0] sd,
                       input bit iv, input logic [7:0] d, input bit l, input logic [2:0] rdy,
                       input bit e_sr, input bit e_ir, input logic [2:0] e_v);
      sel3.valid = sv; sel3.data = sd;
      in3.valid = iv; in3.data[0] = d; in3.last = l; rdy3 = rdy;
      #4;
      check_eq({tag, ".sel_rdy"}, 32'(sel3.ready), 32'(e_sr));
      check_eq({tag, ".in_rdy"},  32'(in3.ready),  32'(e_ir));
      check_eq({tag, ".valid"},   32'(v3),         32'(e_v));
      if (e_v != 3'd0) check_eq({tag, ".data"}, 32'(d3), 32'(d));
      @(posedge clk); #1;
   endtask

   initial begin
      bit   r_pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      int   b;
      logic r;
      logic lb;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      sel4.valid = 1'b1; sel4.data = 2'd2;
      in4.valid = 1'b1; in4.data[0] = 8'hA0; in4.keep = '1; in4.last = 1'b0; rdy4 = 4'hF;
      sel3.valid = 1'b0; sel3.data = 2'd0;
      in3.valid = 1'b0; in3.data[0] = 8'h00; in3.keep = '1; in3.last = 1'b0; rdy3 = 3'h7;

      // Reset held: everything quiet even with valid inputs presented.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #4;
         check_eq($sformatf("rst%0d.sel_rdy", k), 32'(sel4.ready), 32'd0);
         check_eq($sformatf("rst%0d.in_rdy", k),  32'(in4.ready),  32'd0);
         check_eq($sformatf("rst%0d.valid", k),   32'(v4),         32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset then single packet to lane 2.
      cyc4("rel",  0, 2'd0, 0, 8'h00, 0, 4'hF, 0, 0, 4'b0000);
      cyc4("idle", 0, 2'd0, 1, 8'hA0, 0, 4'hF, 1, 0, 4'b0000);
      cyc4("sel2", 1, 2'd2, 1, 8'hA0, 0, 4'hF, 1, 0, 4'b0000);
      cyc4("a0",   0, 2'd0, 1, 8'hA0, 0, 4'hF, 0, 1, 4'b0100);
      cyc4("a1",   0, 2'd0, 1, 8'hA1, 0, 4'hF, 0, 1, 4'b0100);
      cyc4("a2",   0, 2'd0, 1, 8'hA2, 0, 4'hF, 0, 1, 4'b0100);
      cyc4("a3",   0, 2'd0, 1, 8'hA3, 1, 4'hF, 1, 1, 4'b0100);
      cyc4("aend", 0, 2'd0, 1, 8'hA4, 0, 4'hF, 1, 0, 4'b0000);

      // Back-to-back packets with selects 1,3,0 always pending.
      cyc4("bsel", 1, 2'd1, 1, 8'hB0, 0, 4'hF, 1, 0, 4'b0000);
      cyc4("b0",   1, 2'd3, 1, 8'hB0, 0, 4'hF, 0, 1, 4'b0010);
      cyc4("b1",   1, 2'd3, 1, 8'hB1, 1, 4'hF, 1, 1, 4'b0010);
      cyc4("c0",   1, 2'd0, 1, 8'hC0, 0, 4'hF, 0, 1, 4'b1000);
      cyc4("c1",   1, 2'd0, 1, 8'hC1, 1, 4'hF, 1, 1, 4'b1000);
      cyc4("d0",   0, 2'd0, 1, 8'hD0, 0, 4'hF, 0, 1, 4'b0001);
      cyc4("d1",   0, 2'd0, 1, 8'hD1, 1, 4'hF, 1, 1, 4'b0001);
      cyc4("dend", 0, 2'd0, 0, 8'h00, 0, 4'hF, 1, 0, 4'b0000);

      // Backpressure on lane 1: in.ready follows out[1].ready, beat advances only on transfer.
      cyc4("esel", 1, 2'd1, 0, 8'h00, 0, 4'hF, 1, 0, 4'b0000);
      b = 0;
      for (int c = 0; c < 8; c++) begin
         r  = r_pat[c];
         lb = (b == 4);
         cyc4($sformatf("bp%0d", c), 0, 2'd0, 1, 8'hE0 + 8'(b), lb, {2'b11, r, 1'b1},
              lb & r, r, 4'b0010);
         if (r) b++;
      end
      cyc4("eend", 0, 2'd0, 1, 8'hEE, 0, 4'hF, 1, 0, 4'b0000);
      cyc4("quiet", 0, 2'd0, 0, 8'h00, 0, 4'hF, 1, 0, 4'b0000);

      // Out-of-range select on the 3-lane instance drops the packet.
      cyc3("fsel", 1, 2'd3, 1, 8'hF0, 0, 3'b000, 1, 0, 3'b000);
      cyc3("f0",   1, 2'd0, 1, 8'hF0, 0, 3'b000, 0, 1, 3'b000);
      cyc3("f1",   1, 2'd0, 1, 8'hF1, 0, 3'b000, 0, 1, 3'b000);
      cyc3("f2",   1, 2'd0, 1, 8'hF2, 1, 3'b000, 1, 1, 3'b000);
      cyc3("g55",  0, 2'd0, 1, 8'h55, 1, 3'b111, 1, 1, 3'b001);
      cyc3("gend", 0, 2'd0, 1, 8'h56, 0, 3'b111, 1, 0, 3'b000);
      cyc3("q3",   0, 2'd0, 0, 8'h00, 0, 3'b111, 1, 0, 3'b000);

      // Reset in the middle of a packet to lane 2.
      cyc4("hsel", 1, 2'd2, 0, 8'h00, 0, 4'hF, 1, 0, 4'b0000);
      cyc4("h0",   0, 2'd0, 1, 8'h90, 0, 4'hF, 0, 1, 4'b0100);
      rst_n = 1'b0;
      cyc4("hrst", 0, 2'd0, 1, 8'h91, 0, 4'hF, 0, 0, 4'b0000);
      rst_n = 1'b1;
      cyc4("hrel", 0, 2'd0, 1, 8'h91, 0, 4'hF, 0, 0, 4'b0000);
      cyc4("hidl", 0, 2'd0, 1, 8'h91, 0, 4'hF, 1, 0, 4'b0000);
      cyc4("hid2", 0, 2'd0, 1, 8'h92, 1, 4'hF, 1, 0, 4'b0000);

      // Single-beat packets, selects cycling 0..3.
      cyc4("ssel", 1, 2'd0, 0, 8'h00, 0, 4'hF, 1, 0, 4'b0000);
      for (int k = 0; k < 8; k++) begin
         cyc4($sformatf("s%0d", k), k < 7, 2'((k + 1) % 4), 1, 8'h30 + 8'(k), 1, 4'hF,
              1, 1, 4'(1 << (k % 4)));
      end
      cyc4("send", 0, 2'd0, 1, 8'h3F, 1, 4'hF, 1, 0, 4'b0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
